// File: rtl/bash_perm_ctrl.sv
// bash_perm_ctrl: sequencer for the bash-f permutation core.
// Turns prep/start pulses from the register map into a load strobe, a train
// of round-enable pulses with round index, and a result-capture strobe, and
// reports active/ready plus a sticky dropped-request error flag.
module bash_perm_ctrl #(
    parameter int NROUNDS   = 24,
    parameter int ROUND_LAT = 1,
    parameter int RIDX_W    = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prep_i,
    input  logic              start_i,
    output logic              load_o,
    output logic              round_en_o,
    output logic [RIDX_W-1:0] round_idx_o,
    output logic              out_we_o,
    output logic              active_o,
    output logic              rdy_o,
    output logic              err_o
);

    // Wait counter only needs to hold ROUND_LAT-1.
    localparam int WCNT_W = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
    localparam logic [RIDX_W-1:0] LAST_R  = RIDX_W'(NROUNDS - 1);
    localparam logic [WCNT_W-1:0] WLOAD   = WCNT_W'(ROUND_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [RIDX_W-1:0]   rnd_q, rnd_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                prepped_q, prepped_d;
    logic                rdy_q, rdy_d;
    logic                err_q, err_d;

    // State and status registers; reset aborts any run in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            rnd_q     <= '0;
            wcnt_q    <= '0;
            prepped_q <= 1'b0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            wcnt_q    <= wcnt_d;
            prepped_q <= prepped_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: request arbitration, round sequencing, error capture.
    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        wcnt_d    = wcnt_q;
        prepped_d = prepped_q;
        rdy_d     = rdy_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (prep_i) begin
                    // Accepted prep clears the error; a start in the same
                    // cycle is dropped and re-raises it.
                    state_d = S_LOAD;
                    rdy_d   = 1'b0;
                    err_d   = start_i;
                end else if (start_i) begin
                    if (prepped_q) begin
                        state_d   = S_ROUND;
                        rnd_d     = '0;
                        prepped_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                prepped_d = 1'b1;
                state_d   = S_IDLE;
                if (prep_i || start_i) err_d = 1'b1;
            end

            S_ROUND: begin
                if (ROUND_LAT == 1) begin
                    if (rnd_q < LAST_R) rnd_d = rnd_q + RIDX_W'(1);
                    else                state_d = S_CAPTURE;
                end else begin
                    state_d = S_WAIT;
                    wcnt_d  = WLOAD;
                end
                if (prep_i || start_i) err_d = 1'b1;
            end

            S_WAIT: begin
                if (wcnt_q == WCNT_W'(1)) begin
                    if (rnd_q < LAST_R) begin
                        rnd_d   = rnd_q + RIDX_W'(1);
                        state_d = S_ROUND;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
                if (prep_i || start_i) err_d = 1'b1;
            end

            S_CAPTURE: begin
                state_d = S_DONE;
                rdy_d   = 1'b1;
                if (prep_i || start_i) err_d = 1'b1;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    assign load_o      = (state_q == S_LOAD);
    assign round_en_o  = (state_q == S_ROUND);
    assign out_we_o    = (state_q == S_CAPTURE);
    assign active_o    = (state_q == S_ROUND) || (state_q == S_WAIT) ||
                         (state_q == S_CAPTURE);
    assign round_idx_o = rnd_q;
    assign rdy_o       = rdy_q;
    assign err_o       = err_q;

endmodule
